// File: rtl/crono_pkg.sv
// crono_pkg: shared states, BCD limits and BCD helper functions for the countdown timer
package crono_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3} estado_t;
  localparam logic [7:0] BCD_MAX_SEG = 8'h59;
  localparam logic [7:0] BCD_MAX_HORA = 8'h23;
  typedef struct packed {
    logic       borrow;
    logic [7:0] val;
  } dec_t;
  function automatic dec_t bcd_dec2(input logic [7:0] v, input logic [7:0] wrap);
    dec_t r;
    r.borrow = v == 8'h00;
    r.val = r.borrow ? wrap : (v[3:0] != 4'd0) ? v - 8'd1 : {v[7:4] - 4'd1, 4'd9};
    return r;
  endfunction
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic es_hora);
    logic [3:0] u, t;
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    t = (!es_hora && v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    return (es_hora && (v[7:4] > 4'd2 || (v[7:4] == 4'd2 && v[3:0] > 4'd3))) ? BCD_MAX_HORA : {t, u};
  endfunction
endpackage

// File: rtl/cronometro_regresivo_if.sv
// cronometro_regresivo_if: control pulses, BCD setpoint and BCD count/status of the timer
interface cronometro_regresivo_if;
  logic       inicio, pausa, detener;
  logic [7:0] h_set, m_set, s_set;
  logic [7:0] h_run, m_run, s_run;
  logic       finale, corriendo;
  modport master (output inicio, pausa, detener, h_set, m_set, s_set,
                  input  h_run, m_run, s_run, finale, corriendo);
  modport slave  (input  inicio, pausa, detener, h_set, m_set, s_set,
                  output h_run, m_run, s_run, finale, corriendo);
endinterface

// File: rtl/generador_tick.sv
// generador_tick: one-cycle tick every CLK_HZ enabled cycles; limpia clears the partial count
module generador_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic reloj_nexys,
  input  logic reset_total,
  input  logic habilita,
  input  logic limpia,
  output logic tick
);
  localparam int W = $clog2(CLK_HZ + 1);
  localparam logic [W-1:0] ULT = W'(CLK_HZ - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = habilita && cnt_q == ULT;
  assign cnt_d = limpia ? '0 : !habilita ? cnt_q : tick ? '0 : cnt_q + W'(1);
  always_ff @(posedge reloj_nexys) cnt_q <= reset_total ? '0 : cnt_d;
endmodule

// File: rtl/cronometro_regresivo.sv
// cronometro_regresivo: BCD HH:MM:SS countdown with run/pause/done control
module cronometro_regresivo
  import crono_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic reloj_nexys,
  input  logic reset_total,
  cronometro_regresivo_if.slave bus
);
  estado_t     state_q, state_d;
  logic [23:0] cnt_q, cnt_d, sp, cnt_dec;
  logic        tick, is_one, finale_q, corr_q;
  dec_t        ds, dm, dh;
  generador_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .reloj_nexys(reloj_nexys),
    .reset_total(reset_total),
    .habilita   (state_q == ST_RUN),
    .limpia     (state_q == ST_IDLE),
    .tick       (tick)
  );
  assign sp = {bcd_sanitize(bus.h_set, 1'b1), bcd_sanitize(bus.m_set, 1'b0), bcd_sanitize(bus.s_set, 1'b0)};
  assign ds = bcd_dec2(cnt_q[7:0], BCD_MAX_SEG);
  assign dm = bcd_dec2(cnt_q[15:8], BCD_MAX_SEG);
  assign dh = bcd_dec2(cnt_q[23:16], BCD_MAX_HORA);
  assign cnt_dec = {(ds.borrow && dm.borrow) ? dh.val : cnt_q[23:16], ds.borrow ? dm.val : cnt_q[15:8], ds.val};
  // Last second before reaching zero: hours and minutes both 00, seconds 01
  assign is_one = dh.borrow && dm.borrow && cnt_q[7:0] == 8'h01;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (bus.detener) begin
      state_d = ST_IDLE;
      cnt_d = sp;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = sp;
          state_d = !bus.inicio ? ST_IDLE : (sp == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          cnt_d = tick ? cnt_dec : cnt_q;
          state_d = (tick && is_one) ? ST_DONE : bus.pausa ? ST_PAUSE : ST_RUN;
        end
        ST_PAUSE: state_d = bus.inicio ? ST_RUN : ST_PAUSE;
        default: state_d = ST_DONE;
      endcase
    end
  end
  always_ff @(posedge reloj_nexys) begin
    if (reset_total) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      finale_q <= 1'b0;
      corr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      finale_q <= state_d == ST_DONE;
      corr_q <= state_d == ST_RUN;
    end
  end
  assign bus.h_run = cnt_q[23:16];
  assign bus.m_run = cnt_q[15:8];
  assign bus.s_run = cnt_q[7:0];
  assign bus.finale = finale_q;
  assign bus.corriendo = corr_q;
endmodule

// File: tb/tb_cronometro_regresivo.sv
// tb_cronometro_regresivo: directed and randomized checks of the countdown timer
module tb_cronometro_regresivo;
  localparam int CLK = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  int m_st = 0;
  int m_secs = 0;
  int m_ph = 0;
  cronometro_regresivo_if bus ();
  cronometro_regresivo #(.CLK_HZ(CLK)) dut (.reloj_nexys(clk), .reset_total(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int san(input logic [7:0] v, input bit hr);
    int t, u;
    t = int'(v[7:4]);
    u = int'(v[3:0]);
    if (hr && (t > 2 || (t == 2 && u > 3))) return 23;
    if (!hr && t > 5) t = 5;
    if (u > 9) u = 9;
    return t * 10 + u;
  endfunction
  function automatic logic [7:0] to_bcd(input int x);
    return 8'((x / 10) * 16 + x % 10);
  endfunction
  function automatic logic [23:0] exp_bcd(input int s);
    return {to_bcd(s / 3600), to_bcd((s / 60) % 60), to_bcd(s % 60)};
  endfunction
  task automatic model(input bit ini, input bit pau, input bit det, input bit r);
    int sp;
    sp = san(bus.h_set, 1) * 3600 + san(bus.m_set, 0) * 60 + san(bus.s_set, 0);
    if (r) begin
      m_st = 0; m_secs = 0; m_ph = 0;
    end else if (det) begin
      m_st = 0; m_secs = sp; m_ph = 0;
    end else if (m_st == 0) begin
      m_secs = sp; m_ph = 0;
      if (ini) m_st = (sp == 0) ? 3 : 1;
    end else if (m_st == 1) begin
      if (m_ph == CLK - 1) begin
        m_ph = 0;
        m_secs--;
      end else m_ph++;
      if (m_secs == 0) m_st = 3;
      else if (pau) m_st = 2;
    end else if (m_st == 2) begin
      if (ini) m_st = 1;
    end
  endtask
  task automatic step(input bit ini, input bit pau, input bit det, input bit r);
    bus.inicio = ini; bus.pausa = pau; bus.detener = det; rst = r;
    @(posedge clk);
    model(ini, pau, det, r);
    #1;
    bus.inicio = 1'b0; bus.pausa = 1'b0; bus.detener = 1'b0; rst = 1'b0;
  endtask
  task automatic set_sp(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.h_set = h; bus.m_set = m; bus.s_set = s;
  endtask
  task automatic test_reset;
    set_sp(8'h00, 8'h00, 8'h00);
    step(0, 0, 0, 1);
    total++;
    if ({bus.h_run, bus.m_run, bus.s_run, bus.finale, bus.corriendo} !== 26'd0) begin
      bad++;
      $display("FAIL reset: got %h:%h:%h fin=%b run=%b, want 00:00:00 0 0", bus.h_run, bus.m_run, bus.s_run, bus.finale, bus.corriendo);
    end
  endtask
  task automatic test_countdown;
    logic [7:0] e;
    set_sp(8'h00, 8'h00, 8'h03);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int c = 1; c <= 14; c++) begin
      step(0, 0, 0, 0);
      if (c == 3 || c == 4 || c == 8 || c == 12) begin
        e = (c == 3) ? 8'h03 : (c == 4) ? 8'h02 : (c == 8) ? 8'h01 : 8'h00;
        total++;
        if (bus.s_run !== e) begin
          bad++;
          $display("FAIL countdown c=%0d: s_run=%h want %h", c, bus.s_run, e);
        end
      end
      if (c >= 11) begin
        total++;
        if ({bus.finale, bus.corriendo} !== ((c >= 12) ? 2'b10 : 2'b01)) begin
          bad++;
          $display("FAIL countdown flags c=%0d: fin/run=%b%b", c, bus.finale, bus.corriendo);
        end
      end
    end
  endtask
  task automatic test_borrow;
    step(0, 0, 1, 0);
    set_sp(8'h01, 8'h00, 8'h00);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (CLK) step(0, 0, 0, 0);
    total++;
    if ({bus.h_run, bus.m_run, bus.s_run} !== 24'h005959) begin
      bad++;
      $display("FAIL borrow_h: got %h%h%h want 005959", bus.h_run, bus.m_run, bus.s_run);
    end
    repeat (CLK) step(0, 0, 0, 0);
    total++;
    if ({bus.h_run, bus.m_run, bus.s_run} !== 24'h005958) begin
      bad++;
      $display("FAIL borrow_h2: got %h%h%h want 005958", bus.h_run, bus.m_run, bus.s_run);
    end
    step(0, 0, 1, 0);
    set_sp(8'h00, 8'h10, 8'h00);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (CLK) step(0, 0, 0, 0);
    total++;
    if ({bus.h_run, bus.m_run, bus.s_run} !== 24'h000959) begin
      bad++;
      $display("FAIL borrow_m: got %h%h%h want 000959", bus.h_run, bus.m_run, bus.s_run);
    end
  endtask
  task automatic test_pause;
    step(0, 0, 1, 0);
    set_sp(8'h00, 8'h00, 8'h05);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      if (i == 0 || i == 19) begin
        total++;
        if ({bus.s_run, bus.corriendo} !== {8'h04, 1'b0}) begin
          bad++;
          $display("FAIL pause i=%0d: s_run=%h run=%b want 04 0", i, bus.s_run, bus.corriendo);
        end
      end
    end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    total++;
    if (bus.s_run !== 8'h04) begin
      bad++;
      $display("FAIL resume1: s_run=%h want 04", bus.s_run);
    end
    step(0, 0, 0, 0);
    total++;
    if (bus.s_run !== 8'h03) begin
      bad++;
      $display("FAIL resume2: s_run=%h want 03", bus.s_run);
    end
  endtask
  task automatic test_zero;
    step(0, 0, 1, 0);
    set_sp(8'h00, 8'h00, 8'h00);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    total++;
    if ({bus.finale, bus.corriendo} !== 2'b10) begin
      bad++;
      $display("FAIL zero_done: fin/run=%b%b want 10", bus.finale, bus.corriendo);
    end
    step(1, 0, 0, 0);
    total++;
    if ({bus.finale, bus.corriendo} !== 2'b10) begin
      bad++;
      $display("FAIL done_ignores_inicio: fin/run=%b%b want 10", bus.finale, bus.corriendo);
    end
    set_sp(8'h12, 8'h34, 8'h56);
    step(0, 0, 1, 0);
    total++;
    if ({bus.finale, bus.corriendo} !== 2'b00) begin
      bad++;
      $display("FAIL detener: fin/run=%b%b want 00", bus.finale, bus.corriendo);
    end
    step(0, 0, 0, 0);
    total++;
    if ({bus.h_run, bus.m_run, bus.s_run} !== 24'h123456) begin
      bad++;
      $display("FAIL idle_track: got %h%h%h want 123456", bus.h_run, bus.m_run, bus.s_run);
    end
  endtask
  task automatic test_sanitize;
    set_sp(8'h2F, 8'h7A, 8'h6C);
    step(0, 0, 0, 0);
    total++;
    if ({bus.h_run, bus.m_run, bus.s_run} !== 24'h235959) begin
      bad++;
      $display("FAIL sanitize: got %h%h%h want 235959", bus.h_run, bus.m_run, bus.s_run);
    end
    step(1, 0, 0, 0);
    repeat (CLK) step(0, 0, 0, 0);
    total++;
    if ({bus.h_run, bus.m_run, bus.s_run} !== 24'h235958) begin
      bad++;
      $display("FAIL sanitize_run: got %h%h%h want 235958", bus.h_run, bus.m_run, bus.s_run);
    end
  endtask
  task automatic test_priority;
    step(0, 0, 1, 0);
    set_sp(8'h00, 8'h00, 8'h07);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    total++;
    if ({bus.corriendo, bus.s_run} !== {1'b0, 8'h07}) begin
      bad++;
      $display("FAIL det_over_ini: run=%b s_run=%h want 0 07", bus.corriendo, bus.s_run);
    end
    set_sp(8'h00, 8'h00, 8'h03);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (CLK) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    total++;
    if ({bus.h_run, bus.m_run, bus.s_run, bus.finale, bus.corriendo} !== 26'd0) begin
      bad++;
      $display("FAIL reset_mid: got %h%h%h fin=%b run=%b want 000000 0 0", bus.h_run, bus.m_run, bus.s_run, bus.finale, bus.corriendo);
    end
  endtask
  task automatic test_random;
    bit ini, pau, det, r;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0)
        set_sp(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 8'($urandom));
      ini = $urandom_range(0, 9) == 0;
      pau = $urandom_range(0, 19) == 0;
      det = $urandom_range(0, 59) == 0;
      r = $urandom_range(0, 299) == 0;
      step(ini, pau, det, r);
      total++;
      if ({bus.h_run, bus.m_run, bus.s_run} !== exp_bcd(m_secs) || bus.finale !== (m_st == 3) || bus.corriendo !== (m_st == 1)) begin
        bad++;
        $display("FAIL random i=%0d: got %h%h%h fin=%b run=%b want %h fin=%b run=%b", i, bus.h_run, bus.m_run, bus.s_run,
                 bus.finale, bus.corriendo, exp_bcd(m_secs), m_st == 3, m_st == 1);
      end
    end
  endtask
  initial begin
    bus.inicio = 1'b0; bus.pausa = 1'b0; bus.detener = 1'b0;
    set_sp(8'h00, 8'h00, 8'h00);
    #2;
    test_reset;
    test_countdown;
    test_borrow;
    test_pause;
    test_zero;
    test_sanitize;
    test_priority;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
